// File: rtl/wb_burst_master.sv
// Wishbone burst master: takes one burst command at a time and runs a classic or
// incrementing-burst cycle, streaming write beats in and read beats out, with a stall watchdog.
module wb_burst_master #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 26,
    parameter int unsigned LENW    = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              sys_clk,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              done,
    output logic              err,
    output logic [31:0]       err_cnt,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);
    localparam int unsigned    SW        = DW / 8;
    localparam int unsigned    WDW       = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
    localparam logic [AW-1:0]  ADDR_STEP = AW'(SW);

    typedef enum logic [1:0] {StIdle, StLoad, StBus} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [LENW-1:0]   r_beats_left;
    logic [SW-1:0]     r_sel;
    logic [DW-1:0]     r_dat;
    logic              r_single;
    logic [WDW-1:0]    r_wdog;
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_err_cnt;

    logic              w_ack;
    logic              w_last;
    logic              w_timeout;
    logic              w_accept;
    logic              w_wr_take;

    // Ack only counts while strobing; a stray ack in IDLE/LOAD is ignored.
    assign w_ack     = (r_state == StBus) && wb_ack_i;
    assign w_last    = (r_beats_left == LENW'(1));
    assign w_timeout = (r_state == StBus) && !wb_ack_i && (r_wdog == WD_LAST);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_wr_take = wr_valid && wr_ready;

    always_ff @(posedge sys_clk) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        unique case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_d = cmd_we ? StLoad : StBus;
                end
            end
            StLoad: begin
                wb_cyc_o = 1'b1;
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_state_d = StBus;
                end
            end
            StBus: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (wb_ack_i) begin
                    if (w_last) begin
                        w_state_d = StIdle;
                    end else if (r_we) begin
                        wr_ready = 1'b1;
                        if (!wr_valid) begin
                            w_state_d = StLoad;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (RESET) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_single     <= 1'b0;
            r_wdog       <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_accept) begin
                r_we         <= cmd_we;
                r_addr       <= cmd_addr;
                r_sel        <= cmd_sel;
                r_beats_left <= (cmd_len == '0) ? LENW'(1) : cmd_len;
                r_single     <= (cmd_len <= LENW'(1));
            end
            if (w_wr_take) begin
                r_dat <= wr_data;
            end
            if (w_ack) begin
                r_addr       <= r_addr + ADDR_STEP;
                r_beats_left <= r_beats_left - LENW'(1);
                if (!r_we) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= wb_dat_i;
                end
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
            end
            // Watchdog restarts on every ack and stays clear outside the strobe phase.
            r_wdog <= ((r_state == StBus) && !wb_ack_i) ? r_wdog + WDW'(1) : '0;
        end
    end

    assign wb_we_o   = r_we && wb_cyc_o;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_cti_o  = (!wb_cyc_o || r_single) ? 3'b000 : (w_last ? 3'b111 : 3'b010);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
